// File: rtl/md_unit_pkg.sv
// Shared operation codes, widths and helpers for the multiply/divide unit.
package md_unit_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned OP_W        = 4;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    typedef enum logic [OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } md_pair_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct unsigned.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
    endfunction

    function automatic logic is_md_start(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage handshake between the pipeline and the multiply/divide unit.
interface md_unit_if;
    import md_unit_pkg::*;

    logic              Start;
    logic [OP_W-1:0]   MDOp;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              Busy;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;
    logic [DATA_W-1:0] MDOut;

    modport master (output Start, MDOp, A, B, input Busy, HI, LO, MDOut);
    modport slave  (input Start, MDOp, A, B, output Busy, HI, LO, MDOut);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO registers and MFHI/MFLO/MTHI/MTLO access.
module md_unit
    import md_unit_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  md
);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              busy_q, busy_d;

    logic [2*DATA_W-1:0] prod_s, prod_u;
    logic [DATA_W-1:0]   dvd, dvs, quo, rem;
    logic                sdiv;
    md_pair_t            res;

    // Result from the operands captured at Start; the counter alone models latency.
    always_comb begin
        prod_s = 64'($signed(a_q)) * 64'($signed(b_q));
        prod_u = 64'(a_q) * 64'(b_q);
        sdiv   = (op_q == MD_DIV);
        dvd    = sdiv ? mag(a_q) : a_q;
        dvs    = sdiv ? mag(b_q) : b_q;
        quo    = (dvs != '0) ? dvd / dvs : '0;
        rem    = (dvs != '0) ? dvd % dvs : '0;
        res    = '{hi: hi_q, lo: lo_q};
        case (op_q)
            MD_MULT:  res = md_pair_t'(prod_s);
            MD_MULTU: res = md_pair_t'(prod_u);
            MD_DIV: begin
                if (dvs != '0) begin
                    res.lo = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? (~quo + DATA_W'(1)) : quo;
                    res.hi = a_q[DATA_W-1] ? (~rem + DATA_W'(1)) : rem;
                end
            end
            MD_DIVU: begin
                if (dvs != '0) begin
                    res.lo = quo;
                    res.hi = rem;
                end
            end
            default: res = '{hi: hi_q, lo: lo_q};
        endcase
    end

    // Next state; MT* and Start are only honoured while idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (md.Start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    op_d    = md.MDOp;
                    a_d     = md.A;
                    b_d     = md.B;
                    cnt_d   = ((md.MDOp == MD_MULT) || (md.MDOp == MD_MULTU)) ?
                              CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end else if (md.MDOp == MD_MTHI) begin
                    hi_d = md.A;
                end else if (md.MDOp == MD_MTLO) begin
                    lo_d = md.A;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = res.hi;
                    lo_d    = res.lo;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign md.Busy  = busy_q;
    assign md.HI    = hi_q;
    assign md.LO    = lo_q;
    assign md.MDOut = (md.MDOp == MD_MFHI) ? hi_q : lo_q;

endmodule
